// File: rtl/game_stage_ctrl.sv
// Basketball arcade game sequencer: reset banner, idle, pre-play countdown,
// timed stages with a goal target, practice mode and win/lose screens.
module game_stage_ctrl #(
  parameter int TICK_CYCLES = 100_000_000,
  parameter int PRE_CNT     = 3,
  parameter int STAGE_TIME  = 35,
  parameter int NUM_STAGES  = 3,
  parameter int STAGE_GOAL  = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic       pmode,
  input  logic       back,
  input  logic       goal,
  output logic [3:0] dig0,
  output logic [3:0] dig1,
  output logic [3:0] dig2,
  output logic [3:0] dig3,
  output logic [3:0] c_state,
  output logic [1:0] stage,
  output logic       paused,
  output logic       goal_ok,
  output logic       cnt_beep
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_B_RST  = 4'd1,
    S_B_PLAY = 4'd2,
    S_STAGE  = 4'd3,
    S_PMODE  = 4'd6,
    S_WIN    = 4'd7,
    S_LOSE   = 4'd8
  } state_t;

  localparam int             CW          = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0]  TICK_LAST   = CW'(TICK_CYCLES - 1);
  localparam logic [3:0]     PRE_INIT    = 4'(PRE_CNT);
  localparam logic [3:0]     TIME_HI     = 4'(STAGE_TIME / 10);
  localparam logic [3:0]     TIME_LO     = 4'(STAGE_TIME % 10);
  localparam logic [1:0]     LAST_STAGE  = 2'(NUM_STAGES);
  localparam logic [6:0]     GOAL_TARGET = 7'(STAGE_GOAL);

  localparam logic [3:0] D_BLANK = 4'd10;
  localparam logic [3:0] D_DASH  = 4'd11;
  localparam logic [3:0] D_PASS  = 4'd12;
  localparam logic [3:0] D_LOSE  = 4'd13;

  state_t        state_q, state_d;
  logic [CW-1:0] tick_cnt_q, tick_cnt_d;
  logic [3:0]    pre_q, pre_d;
  logic [3:0]    timer_hi_q, timer_hi_d;
  logic [3:0]    timer_lo_q, timer_lo_d;
  logic [3:0]    score_hi_q, score_hi_d;
  logic [3:0]    score_lo_q, score_lo_d;
  logic [1:0]    stage_q, stage_d;
  logic          paused_q, paused_d;
  logic          goal_ok_q, goal_ok_d;
  logic          cnt_beep_q, cnt_beep_d;

  logic          tick;
  logic          goal_acc;
  logic          expire;
  logic          launch;
  logic          pass;
  logic [3:0]    score_inc_hi, score_inc_lo;
  logic [3:0]    score_nx_hi, score_nx_lo;
  logic [6:0]    score_bin;

  assign tick     = (tick_cnt_q == TICK_LAST) && !paused_q;
  assign goal_acc = goal && (((state_q == S_STAGE) && !paused_q) || (state_q == S_PMODE));
  assign expire   = (state_q == S_STAGE) && tick && (timer_hi_q == 4'd0) && (timer_lo_q == 4'd1);

  // Saturating BCD increment; the pass/lose decision sees a goal from the same cycle.
  always_comb begin
    score_inc_hi = score_hi_q;
    score_inc_lo = score_lo_q;
    if (!((score_hi_q == 4'd9) && (score_lo_q == 4'd9))) begin
      if (score_lo_q == 4'd9) begin
        score_inc_hi = score_hi_q + 4'd1;
        score_inc_lo = 4'd0;
      end else begin
        score_inc_lo = score_lo_q + 4'd1;
      end
    end
  end

  assign score_nx_hi = goal_acc ? score_inc_hi : score_hi_q;
  assign score_nx_lo = goal_acc ? score_inc_lo : score_lo_q;
  assign score_bin   = 7'(score_nx_hi) * 7'd10 + 7'(score_nx_lo);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = paused_q ? tick_cnt_q : (tick ? '0 : tick_cnt_q + CW'(1));
    pre_d      = pre_q;
    timer_hi_d = timer_hi_q;
    timer_lo_d = timer_lo_q;
    score_hi_d = score_nx_hi;
    score_lo_d = score_nx_lo;
    stage_d    = stage_q;
    paused_d   = paused_q;
    goal_ok_d  = goal_acc;
    cnt_beep_d = 1'b0;
    launch     = 1'b0;
    pass       = 1'b0;

    case (state_q)
      S_B_RST: begin
        if (tick) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (start)      launch  = 1'b1;
        else if (pmode) state_d = S_PMODE;
      end
      S_B_PLAY: begin
        if (tick) begin
          cnt_beep_d = 1'b1;
          if (pre_q == 4'd1) begin
            state_d    = S_STAGE;
            timer_hi_d = TIME_HI;
            timer_lo_d = TIME_LO;
            score_hi_d = 4'd0;
            score_lo_d = 4'd0;
            tick_cnt_d = '0;
          end else begin
            pre_d = pre_q - 4'd1;
          end
        end
      end
      S_STAGE: begin
        if (tick) begin
          if (timer_lo_q == 4'd0) begin
            timer_lo_d = 4'd9;
            timer_hi_d = timer_hi_q - 4'd1;
          end else begin
            timer_lo_d = timer_lo_q - 4'd1;
          end
        end
        // Expiry outranks back, which outranks the pause toggle.
        if (expire) begin
          paused_d = 1'b0;
          if (score_bin >= GOAL_TARGET) begin
            if (stage_q < LAST_STAGE) pass    = 1'b1;
            else                      state_d = S_WIN;
          end else begin
            state_d = S_LOSE;
          end
        end else if (back) begin
          state_d  = S_IDLE;
          paused_d = 1'b0;
        end else if (stop) begin
          paused_d = ~paused_q;
        end
      end
      S_PMODE: begin
        if (back) state_d = S_IDLE;
      end
      S_WIN, S_LOSE: begin
        if (start)     launch  = 1'b1;
        else if (back) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (launch) begin
      stage_d    = 2'd1;
      score_hi_d = 4'd0;
      score_lo_d = 4'd0;
    end
    if (pass) stage_d = stage_q + 2'd1;
    if (launch || pass) begin
      state_d    = S_B_PLAY;
      pre_d      = PRE_INIT;
      tick_cnt_d = '0;
      cnt_beep_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_B_RST;
      tick_cnt_q <= '0;
      pre_q      <= 4'd0;
      timer_hi_q <= 4'd0;
      timer_lo_q <= 4'd0;
      score_hi_q <= 4'd0;
      score_lo_q <= 4'd0;
      stage_q    <= 2'd1;
      paused_q   <= 1'b0;
      goal_ok_q  <= 1'b0;
      cnt_beep_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      pre_q      <= pre_d;
      timer_hi_q <= timer_hi_d;
      timer_lo_q <= timer_lo_d;
      score_hi_q <= score_hi_d;
      score_lo_q <= score_lo_d;
      stage_q    <= stage_d;
      paused_q   <= paused_d;
      goal_ok_q  <= goal_ok_d;
      cnt_beep_q <= cnt_beep_d;
    end
  end

  always_comb begin
    dig0 = D_BLANK;
    dig1 = D_BLANK;
    dig2 = D_BLANK;
    dig3 = D_BLANK;
    case (state_q)
      S_B_RST: begin
        dig0 = 4'd8;
        dig1 = 4'd8;
        dig2 = 4'd8;
        dig3 = 4'd8;
      end
      S_B_PLAY: begin
        dig0 = D_DASH;
        dig1 = D_DASH;
        dig2 = pre_q;
        dig3 = D_DASH;
      end
      S_STAGE: begin
        dig0 = score_lo_q;
        dig1 = score_hi_q;
        dig2 = timer_lo_q;
        dig3 = timer_hi_q;
      end
      S_PMODE: begin
        dig0 = score_lo_q;
        dig1 = score_hi_q;
        dig2 = 4'd0;
        dig3 = 4'd0;
      end
      S_WIN: begin
        dig0 = score_lo_q;
        dig1 = score_hi_q;
        dig2 = D_PASS;
        dig3 = D_PASS;
      end
      S_LOSE: begin
        dig0 = score_lo_q;
        dig1 = score_hi_q;
        dig2 = D_LOSE;
        dig3 = D_LOSE;
      end
      default: ;
    endcase
  end

  assign c_state  = state_q;
  assign stage    = stage_q;
  assign paused   = paused_q;
  assign goal_ok  = goal_ok_q;
  assign cnt_beep = cnt_beep_q;

endmodule

// File: tb/tb_game_stage_ctrl.sv
// Bench for game_stage_ctrl: directed vector table, hand-written corner cases
// and random pulses, all checked against a second-granularity game model.
module tb_game_stage_ctrl;

  localparam int TICK  = 4;
  localparam int PRE   = 3;
  localparam int STIME = 5;
  localparam int NST   = 2;
  localparam int GOALS = 2;

  // input pulse bits {start, stop, pmode, back, goal}
  localparam logic [4:0] NONE = 5'b00000;
  localparam logic [4:0] IS   = 5'b10000;
  localparam logic [4:0] IP   = 5'b01000;
  localparam logic [4:0] IPM  = 5'b00100;
  localparam logic [4:0] IB   = 5'b00010;
  localparam logic [4:0] IG   = 5'b00001;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0, stop = 1'b0, pmode = 1'b0, back = 1'b0, goal = 1'b0;
  logic [3:0] dig0, dig1, dig2, dig3, c_state;
  logic [1:0] stage;
  logic       paused, goal_ok, cnt_beep;

  always #5 clk = ~clk;

  game_stage_ctrl #(
    .TICK_CYCLES(TICK), .PRE_CNT(PRE), .STAGE_TIME(STIME),
    .NUM_STAGES(NST), .STAGE_GOAL(GOALS)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .pmode(pmode),
    .back(back), .goal(goal), .dig0(dig0), .dig1(dig1), .dig2(dig2),
    .dig3(dig3), .c_state(c_state), .stage(stage), .paused(paused),
    .goal_ok(goal_ok), .cnt_beep(cnt_beep)
  );

  int tests = 0;
  int fails = 0;
  int beep_seen = 0;

  // Game model: score and timer as plain integers, seconds counted in cycles.
  int m_state, m_stage, m_score, m_timer, m_pre, m_cnt;
  bit m_paused, m_gok, m_beep;

  function automatic void model_reset();
    m_state = 1; m_stage = 1; m_score = 0; m_timer = 0; m_pre = 0; m_cnt = 0;
    m_paused = 0; m_gok = 0; m_beep = 0;
  endfunction

  function automatic void enter_countdown();
    m_state = 2; m_pre = PRE; m_cnt = 0; m_beep = 1;
  endfunction

  function automatic void new_game();
    m_stage = 1; m_score = 0;
    enter_countdown();
  endfunction

  function automatic void model_step(input logic [4:0] in);
    bit s, p, pm, b, g, tick, acc;
    s = in[4]; p = in[3]; pm = in[2]; b = in[1]; g = in[0];
    tick = !m_paused && (m_cnt == TICK - 1);
    if (!m_paused) m_cnt = tick ? 0 : m_cnt + 1;
    m_gok = 0; m_beep = 0;
    acc = g && ((m_state == 3 && !m_paused) || m_state == 6);
    if (acc) begin
      m_gok = 1;
      if (m_score < 99) m_score++;
    end
    case (m_state)
      1: if (tick) m_state = 0;
      0: if (s) new_game(); else if (pm) m_state = 6;
      2: if (tick) begin
           m_beep = 1;
           if (m_pre == 1) begin
             m_state = 3; m_timer = STIME; m_score = 0; m_cnt = 0;
           end else m_pre--;
         end
      3: if (tick && m_timer == 1) begin
           m_timer = 0; m_paused = 0;
           if (m_score >= GOALS) begin
             if (m_stage < NST) begin m_stage++; enter_countdown(); end
             else m_state = 7;
           end else m_state = 8;
         end else begin
           if (tick) m_timer--;
           if (b) begin m_state = 0; m_paused = 0; end
           else if (p) m_paused = !m_paused;
         end
      6: if (b) m_state = 0;
      7, 8: if (s) new_game(); else if (b) m_state = 0;
      default: ;
    endcase
  endfunction

  function automatic logic [15:0] model_digits();
    logic [3:0] sh, sl, th, tl;
    sh = 4'(m_score / 10); sl = 4'(m_score % 10);
    th = 4'(m_timer / 10); tl = 4'(m_timer % 10);
    case (m_state)
      1: return 16'h8888;
      2: return {4'hB, 4'(m_pre), 4'hB, 4'hB};
      3: return {th, tl, sh, sl};
      6: return {4'h0, 4'h0, sh, sl};
      7: return {4'hC, 4'hC, sh, sl};
      8: return {4'hD, 4'hD, sh, sl};
      default: return 16'hAAAA;
    endcase
  endfunction

  task automatic check_model(input string tag);
    logic [24:0] act, exp;
    act = {c_state, stage, paused, goal_ok, cnt_beep, dig3, dig2, dig1, dig0};
    exp = {4'(m_state), 2'(m_stage), m_paused, m_gok, m_beep, model_digits()};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t {state,stage,paused,goal_ok,beep,dig3..0}: got %h want %h",
               tag, $time, act, exp);
    end
  endtask

  // One clock: drive pulses, advance model, sample #1 after the edge.
  task automatic cycle(input logic [4:0] in, input string tag);
    {start, stop, pmode, back, goal} = in;
    model_step(in);
    @(posedge clk);
    #1;
    {start, stop, pmode, back, goal} = NONE;
    if (cnt_beep) beep_seen++;
    check_model(tag);
  endtask

  task automatic expect_val(input string tag, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h want %h", tag, got, want);
    end
  endtask

  typedef struct {
    logic [4:0]  in;
    int          wait_n;
    logic [3:0]  st;
    logic [1:0]  stg;
    logic        pz;
    logic [15:0] dig;
  } vec_t;

  vec_t vecs[38];

  function automatic vec_t mk(logic [4:0] in, int w, logic [3:0] st, logic [1:0] stg,
                              logic pz, logic [15:0] dig);
    vec_t v;
    v.in = in; v.wait_n = w; v.st = st; v.stg = stg; v.pz = pz; v.dig = dig;
    return v;
  endfunction

  initial begin
    // dig packed as {dig3, dig2, dig1, dig0}
    vecs[0]  = mk(NONE,  2, 4'd1, 2'd1, 1'b0, 16'h8888);
    vecs[1]  = mk(NONE,  0, 4'd0, 2'd1, 1'b0, 16'hAAAA);
    vecs[2]  = mk(IS,    0, 4'd2, 2'd1, 1'b0, 16'hB3BB);
    vecs[3]  = mk(NONE,  3, 4'd2, 2'd1, 1'b0, 16'hB2BB);
    vecs[4]  = mk(NONE,  3, 4'd2, 2'd1, 1'b0, 16'hB1BB);
    vecs[5]  = mk(NONE,  3, 4'd3, 2'd1, 1'b0, 16'h0500);
    vecs[6]  = mk(IG,    0, 4'd3, 2'd1, 1'b0, 16'h0501);
    vecs[7]  = mk(IG,    0, 4'd3, 2'd1, 1'b0, 16'h0502);
    vecs[8]  = mk(NONE,  0, 4'd3, 2'd1, 1'b0, 16'h0502);
    vecs[9]  = mk(NONE,  0, 4'd3, 2'd1, 1'b0, 16'h0402);
    vecs[10] = mk(IP,    0, 4'd3, 2'd1, 1'b1, 16'h0402);
    vecs[11] = mk(IG,   19, 4'd3, 2'd1, 1'b1, 16'h0402);
    vecs[12] = mk(IP,    0, 4'd3, 2'd1, 1'b0, 16'h0402);
    vecs[13] = mk(NONE,  1, 4'd3, 2'd1, 1'b0, 16'h0402);
    vecs[14] = mk(NONE,  0, 4'd3, 2'd1, 1'b0, 16'h0302);
    vecs[15] = mk(NONE,  7, 4'd3, 2'd1, 1'b0, 16'h0102);
    vecs[16] = mk(NONE,  3, 4'd2, 2'd2, 1'b0, 16'hB3BB);
    vecs[17] = mk(NONE, 11, 4'd3, 2'd2, 1'b0, 16'h0500);
    vecs[18] = mk(IG,    0, 4'd3, 2'd2, 1'b0, 16'h0501);
    vecs[19] = mk(IG,    0, 4'd3, 2'd2, 1'b0, 16'h0502);
    vecs[20] = mk(IG,    0, 4'd3, 2'd2, 1'b0, 16'h0503);
    vecs[21] = mk(NONE, 15, 4'd3, 2'd2, 1'b0, 16'h0103);
    vecs[22] = mk(NONE,  0, 4'd7, 2'd2, 1'b0, 16'hCC03);
    vecs[23] = mk(IS,    0, 4'd2, 2'd1, 1'b0, 16'hB3BB);
    vecs[24] = mk(NONE, 11, 4'd3, 2'd1, 1'b0, 16'h0500);
    vecs[25] = mk(IG,    0, 4'd3, 2'd1, 1'b0, 16'h0501);
    vecs[26] = mk(NONE, 17, 4'd3, 2'd1, 1'b0, 16'h0101);
    vecs[27] = mk(IG,    0, 4'd2, 2'd2, 1'b0, 16'hB3BB);
    vecs[28] = mk(NONE, 11, 4'd3, 2'd2, 1'b0, 16'h0500);
    vecs[29] = mk(IG,    0, 4'd3, 2'd2, 1'b0, 16'h0501);
    vecs[30] = mk(NONE, 18, 4'd8, 2'd2, 1'b0, 16'hDD01);
    vecs[31] = mk(IS,   12, 4'd3, 2'd1, 1'b0, 16'h0500);
    vecs[32] = mk(NONE, 18, 4'd3, 2'd1, 1'b0, 16'h0100);
    vecs[33] = mk(IB,    0, 4'd8, 2'd1, 1'b0, 16'hDD00);
    vecs[34] = mk(IS,   12, 4'd3, 2'd1, 1'b0, 16'h0500);
    vecs[35] = mk(IP,    0, 4'd3, 2'd1, 1'b1, 16'h0500);
    vecs[36] = mk(IB,    0, 4'd0, 2'd1, 1'b0, 16'hAAAA);
    vecs[37] = mk(IPM,   0, 4'd6, 2'd1, 1'b0, 16'h0000);

    // Reset held, then released just after an edge.
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_model("reset");
    rst = 1'b1;

    for (int i = 0; i < 38; i++) begin
      if (i == 2) beep_seen = 0;
      cycle(vecs[i].in, "model");
      for (int w = 0; w < vecs[i].wait_n; w++) cycle(NONE, "model");
      tests++;
      if ({c_state, stage, paused, dig3, dig2, dig1, dig0} !==
          {vecs[i].st, vecs[i].stg, vecs[i].pz, vecs[i].dig}) begin
        fails++;
        $display("FAIL vec%0d {state,stage,paused,digits}: got %h want %h", i,
                 {c_state, stage, paused, dig3, dig2, dig1, dig0},
                 {vecs[i].st, vecs[i].stg, vecs[i].pz, vecs[i].dig});
      end
      if (i == 5) expect_val("countdown_beeps", 32'(beep_seen), 32'd4);
    end

    // Practice mode saturation, exit, and asynchronous abort.
    for (int k = 0; k < 100; k++) cycle(IG, "pmode_goal");
    expect_val("pmode_sat", {16'h0, dig3, dig2, dig1, dig0}, 32'h0000_0099);
    cycle(IB, "pmode_back");
    expect_val("pmode_back_state", 32'(c_state), 32'd0);
    cycle(IPM, "pmode_reenter");
    expect_val("pmode_reenter_state", 32'(c_state), 32'd6);
    rst = 1'b0;
    #1;
    expect_val("async_rst", {16'h0, c_state, 2'b00, stage, 3'b000, paused, goal_ok, cnt_beep},
               {16'h0, 4'd1, 2'b00, 2'd1, 3'b000, 1'b0, 1'b0, 1'b0});
    expect_val("async_rst_dig", {16'h0, dig3, dig2, dig1, dig0}, 32'h0000_8888);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_model("reset_hold");
    rst = 1'b1;

    // Random pulses against the model.
    for (int n = 0; n < 4000; n++) begin
      logic [4:0] in;
      in[4] = ($urandom_range(0, 99) < 2);
      in[3] = ($urandom_range(0, 99) < 3);
      in[2] = ($urandom_range(0, 99) < 3);
      in[1] = ($urandom_range(0, 99) < 2);
      in[0] = ($urandom_range(0, 99) < 30);
      cycle(in, "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
